// File: rtl/v_period_meter.sv
// Measures the period and high time of an asynchronous periodic input in clock cycles.
// Reports each capture with a one-cycle valid pulse, plus sticky overflow and a lock indicator.
module v_period_meter #(
    parameter int width = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [width-1:0] period,
    output logic [width-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [width-1:0] CNT_MAX = '1;
    localparam logic [width-1:0] CNT_ONE = width'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [width-1:0] r_cnt;
    logic [width-1:0] r_hi_cnt;
    logic [width-1:0] r_period;
    logic [width-1:0] r_high_time;
    logic             r_valid;
    logic             r_overflow;
    logic             r_locked;
    logic             r_have_prev;
    logic             w_rise;
    logic             w_capture;
    logic             w_ovf_hit;
    logic             w_match;

    // Two flops resolve metastability; the third gives the previous level for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise  = r_sync2 & ~r_sync3;
    assign w_match = (r_cnt == r_period) && (r_hi_cnt == r_high_time);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_ovf_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_next = ARM;
                end
            end
            ARM: begin
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (w_rise) begin
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                // Disable beats a capture, and a capture beats overflow on the same cycle.
                if (!enable) begin
                    w_state_next = IDLE;
                end else if (w_rise) begin
                    w_capture = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_ovf_hit    = 1'b1;
                    w_state_next = ARM;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_hi_cnt    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_locked    <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!enable) begin
                // Measurements are kept so software can still read the last result.
                r_cnt       <= '0;
                r_hi_cnt    <= '0;
                r_overflow  <= 1'b0;
                r_locked    <= 1'b0;
                r_have_prev <= 1'b0;
            end else begin
                case (r_state)
                    ARM: begin
                        if (w_rise) begin
                            r_cnt    <= CNT_ONE;
                            r_hi_cnt <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (w_capture) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_cnt;
                            r_valid     <= 1'b1;
                            r_overflow  <= 1'b0;
                            r_locked    <= r_have_prev && w_match;
                            r_have_prev <= 1'b1;
                            r_cnt       <= CNT_ONE;
                            r_hi_cnt    <= CNT_ONE;
                        end else if (w_ovf_hit) begin
                            // Lock history is meaningless across a lost edge.
                            r_overflow  <= 1'b1;
                            r_locked    <= 1'b0;
                            r_have_prev <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + CNT_ONE;
                            r_hi_cnt <= r_hi_cnt + {{(width-1){1'b0}}, r_sync2};
                        end
                    end
                    default: begin
                        r_cnt    <= '0;
                        r_hi_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign overflow  = r_overflow;
    assign locked    = r_locked;

endmodule

// File: tb/tb_v_period_meter.sv
// Self-checking bench for v_period_meter (width=8): a waveform model pushes the
// expected capture for every measured period; a monitor pops one entry per valid pulse.
module tb_v_period_meter;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         enable;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         overflow;
    logic         locked;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         lk;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // Waveform model state
    bit           edge_seen = 1'b0;
    bit           have_prev = 1'b0;
    int           last_hi   = 0;
    int           last_lo   = 0;
    logic [W-1:0] prev_p    = '0;
    logic [W-1:0] prev_h    = '0;

    v_period_meter #(.width(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overflow  (overflow),
        .locked    (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard consumer: every valid pulse must match the oldest expected capture.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && valid === 1'b1) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: period=%0d high_time=%0d, required no valid", period, high_time);
            end else begin
                e = sb_q.pop_front();
                if (period !== e.p || high_time !== e.h || locked !== e.lk || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL capture: got p=%0d h=%0d lk=%b ovf=%b, required p=%0d h=%0d lk=%b ovf=0",
                             period, high_time, locked, overflow, e.p, e.h, e.lk);
                end else begin
                    $display("capture p=%0d h=%0d locked=%b ok", period, high_time, locked);
                end
            end
        end
    end

    // Drive one period starting with a rising edge; that edge completes the previous period.
    task automatic drive_period(input int h, input int l);
        exp_t e;
        if (edge_seen) begin
            e.p  = W'(last_hi + last_lo);
            e.h  = W'(last_hi);
            e.lk = have_prev && (e.p == prev_p) && (e.h == prev_h);
            sb_q.push_back(e);
            prev_p    = e.p;
            prev_h    = e.h;
            have_prev = 1'b1;
        end
        edge_seen = 1'b1;
        last_hi   = h;
        last_lo   = l;
        sig_in = 1'b1;
        repeat (h) @(posedge clock);
        #1;
        sig_in = 1'b0;
        repeat (l) @(posedge clock);
        #1;
    endtask

    task automatic idle_low(input int n);
        sig_in = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        last_lo += n;
    endtask

    task automatic rearm_model();
        edge_seen = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({period, high_time, valid, overflow, locked} !== '0) begin
            failures++;
            $display("FAIL reset_state: p=%0d h=%0d v=%b o=%b l=%b, required all 0", period, high_time, valid, overflow, locked);
        end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({period, high_time, valid, overflow, locked} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: p=%0d h=%0d v=%b o=%b l=%b, required all 0", period, high_time, valid, overflow, locked);
        end
    endtask

    task automatic test_basic();
        enable = 1'b1;
        rearm_model();
        repeat (5) drive_period(2, 2);
        idle_low(4);
        checks++;
        if (period !== 8'd4 || high_time !== 8'd2 || locked !== 1'b1) begin
            failures++;
            $display("FAIL basic_2_2: p=%0d h=%0d l=%b, required p=4 h=2 l=1", period, high_time, locked);
        end
    endtask

    task automatic test_shapes();
        repeat (4) drive_period(3, 2);
        repeat (4) drive_period(1, 1);
        idle_low(4);
        checks++;
        if (period !== 8'd2 || high_time !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL shape_1_1: p=%0d h=%0d l=%b, required p=2 h=1 l=1", period, high_time, locked);
        end
    endtask

    task automatic test_period_change();
        repeat (3) drive_period(2, 2);
        repeat (3) drive_period(3, 3);
        idle_low(4);
        checks++;
        if (period !== 8'd6 || high_time !== 8'd3 || locked !== 1'b1) begin
            failures++;
            $display("FAIL period_change: p=%0d h=%0d l=%b, required p=6 h=3 l=1", period, high_time, locked);
        end
    endtask

    task automatic test_overflow();
        int n;
        repeat (3) drive_period(2, 2);
        n = 0;
        sig_in = 1'b0;
        while (overflow !== 1'b1 && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (overflow !== 1'b1 || n < 245 || n > 265) begin
            failures++;
            $display("FAIL overflow_timing: overflow=%b after %0d cycles, required 1 after ~254", overflow, n);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL overflow_locked: locked=%b, required 0", locked);
        end
        rearm_model();
        drive_period(2, 2);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: overflow=%b after first edge, required 1", overflow);
        end
        repeat (2) drive_period(2, 2);
        idle_low(4);
        checks++;
        if (overflow !== 1'b0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL overflow_recover: overflow=%b locked=%b, required 0 and 1", overflow, locked);
        end
    endtask

    task automatic test_enable_low();
        logic [W-1:0] hold_p;
        logic [W-1:0] hold_h;
        int bad;
        repeat (3) drive_period(2, 2);
        drive_period(3, 2);
        idle_low(4);
        hold_p = prev_p;
        hold_h = prev_h;
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            sig_in = ~sig_in;
            @(posedge clock);
            #1;
            if (valid !== 1'b0 || overflow !== 1'b0 || locked !== 1'b0 || period !== hold_p || high_time !== hold_h)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL enable_low_hold: %0d bad cycles, last v=%b o=%b l=%b p=%0d h=%0d, required 0/0/0 p=%0d h=%0d",
                     bad, valid, overflow, locked, period, high_time, hold_p, hold_h);
        end
        sig_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        enable = 1'b1;
        rearm_model();
        drive_period(2, 2);
        checks++;
        if (period !== hold_p || sb_q.size() != 0) begin
            failures++;
            $display("FAIL enable_first_edge: p=%0d queued=%0d, required p=%0d and no capture", period, sb_q.size(), hold_p);
        end
        repeat (2) drive_period(2, 2);
        idle_low(4);
    endtask

    task automatic test_reset_mid();
        repeat (3) drive_period(2, 2);
        sig_in = 1'b1;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        sig_in  = 1'b0;
        #1;
        checks++;
        if ({period, high_time, valid, overflow, locked} !== '0) begin
            failures++;
            $display("FAIL async_reset: p=%0d h=%0d v=%b o=%b l=%b, required all 0", period, high_time, valid, overflow, locked);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rearm_model();
        drive_period(2, 2);
        checks++;
        if (period !== 8'd0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL reset_first_edge: p=%0d queued=%0d, required p=0 and no capture", period, sb_q.size());
        end
        repeat (3) drive_period(2, 2);
        idle_low(4);
        checks++;
        if (period !== 8'd4 || locked !== 1'b1) begin
            failures++;
            $display("FAIL reset_relock: p=%0d l=%b, required p=4 l=1", period, locked);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        test_reset();
        test_basic();
        test_shapes();
        test_period_change();
        test_overflow();
        test_enable_low();
        test_reset_mid();
        repeat (8) @(posedge clock);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d captures missing, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
